spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 44 ++++
 rtl/spi_slave.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pins and the parallel consumer/producer handshake of
// spi_slave. The system clock and reset stay plain ports on the block itself.
//
// Signals:
//   SPI_SLAVE_SCK_In, SPI_SLAVE_MOSI_In, SPI_SLAVE_SS_InLow : serial pins from master
//   SPI_SLAVE_MISO_Out                                     : serial data to master
//   SPI_SLAVE_txData_In / SPI_SLAVE_txLoad_InHigh          : next word to transmit + load strobe
//   SPI_SLAVE_rxRead_InHigh                                : consumer acknowledge of data_Out
//   SPI_SLAVE_data_Out / newData_Out / rxValid_Out         : received word and its status
//   SPI_SLAVE_overrun_Out / busy_Out                       : sticky overrun flag, frame activity
// Modports: slave (the block), master (the surrounding logic / bench).
// -----------------------------------------------------------------------------
interface spi_slave_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic                     SPI_SLAVE_SCK_In;
    logic                     SPI_SLAVE_MOSI_In;
    logic                     SPI_SLAVE_SS_InLow;
    logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_txData_In;
    logic                     SPI_SLAVE_txLoad_InHigh;
    logic                     SPI_SLAVE_rxRead_InHigh;
    logic                     SPI_SLAVE_MISO_Out;
    logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_data_Out;
    logic                     SPI_SLAVE_newData_Out;
    logic                     SPI_SLAVE_rxValid_Out;
    logic                     SPI_SLAVE_overrun_Out;
    logic                     SPI_SLAVE_busy_Out;

    modport slave (
        input  SPI_SLAVE_SCK_In, SPI_SLAVE_MOSI_In, SPI_SLAVE_SS_InLow,
        input  SPI_SLAVE_txData_In, SPI_SLAVE_txLoad_InHigh, SPI_SLAVE_rxRead_InHigh,
        output SPI_SLAVE_MISO_Out, SPI_SLAVE_data_Out, SPI_SLAVE_newData_Out,
        output SPI_SLAVE_rxValid_Out, SPI_SLAVE_overrun_Out, SPI_SLAVE_busy_Out
    );

    modport master (
        output SPI_SLAVE_SCK_In, SPI_SLAVE_MOSI_In, SPI_SLAVE_SS_InLow,
        output SPI_SLAVE_txData_In, SPI_SLAVE_txLoad_InHigh, SPI_SLAVE_rxRead_InHigh,
        input  SPI_SLAVE_MISO_Out, SPI_SLAVE_data_Out, SPI_SLAVE_newData_Out,
        input  SPI_SLAVE_rxValid_Out, SPI_SLAVE_overrun_Out, SPI_SLAVE_busy_Out
    );
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 slave, MSB first, oversampled by the system clock. SCK, MOSI and
// SS are synchronized (2 flops) and edges are detected on the synchronized
// copies. Received words are presented on data_Out with a newData pulse and
// a rxValid/overrun handshake; transmit words come from a holding register
// loaded by txLoad and retransmitted until reloaded.
//
// Ports:
//   SPI_SLAVE_CLOCK_50     : system clock, rising edge
//   SPI_SLAVE_RESET_InLow  : asynchronous active-low reset
//   bus (spi_slave_if.slave): serial pins and parallel handshake
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 2
) (
    input  logic         SPI_SLAVE_CLOCK_50,
    input  logic         SPI_SLAVE_RESET_InLow,
    spi_slave_if.slave   bus
);
    localparam int W  = DATAWIDTH_BUS;
    localparam int CW = $clog2(DATAWIDTH_BUS + 1);

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE  = STATE_SIZE'(0),
        SHIFT = STATE_SIZE'(1),
        DONE  = STATE_SIZE'(2)
    } state_t;

    state_t          state_r, state_next_s;
    logic            sck_meta_r, sck_sync_r, sck_prev_r;
    logic            mosi_meta_r, mosi_sync_r;
    logic            ss_meta_r, ss_sync_r, ss_prev_r;
    logic [CW-1:0]   cnt_r, cnt_next_s;
    logic [W-1:0]    rx_r, rx_next_s;
    logic [W-1:0]    tx_r, tx_next_s;
    logic [W-1:0]    hold_r;
    logic [W-1:0]    data_r, data_next_s;
    logic            miso_r, miso_next_s;
    logic            valid_r, valid_next_s;
    logic            ovr_r, ovr_next_s;
    logic            new_data_r, busy_r;
    logic            sck_rise_s, sck_fall_s, ss_fall_s;

    assign sck_rise_s =  sck_sync_r & ~sck_prev_r;
    assign sck_fall_s = ~sck_sync_r &  sck_prev_r;
    // ss_prev resets to 0, so the 0 reset value of the SS synchronizer can
    // never be mistaken for a frame start after reset release.
    assign ss_fall_s  = ~ss_sync_r  &  ss_prev_r;

    // Input synchronizers plus the one-cycle-delayed copies used for edge detection.
    always_ff @(posedge SPI_SLAVE_CLOCK_50 or negedge SPI_SLAVE_RESET_InLow) begin
        if (!SPI_SLAVE_RESET_InLow) begin
            sck_meta_r  <= 1'b0; sck_sync_r  <= 1'b0; sck_prev_r <= 1'b0;
            mosi_meta_r <= 1'b0; mosi_sync_r <= 1'b0;
            ss_meta_r   <= 1'b0; ss_sync_r   <= 1'b0; ss_prev_r  <= 1'b0;
        end else begin
            sck_meta_r  <= bus.SPI_SLAVE_SCK_In;   sck_sync_r  <= sck_meta_r;  sck_prev_r <= sck_sync_r;
            mosi_meta_r <= bus.SPI_SLAVE_MOSI_In;  mosi_sync_r <= mosi_meta_r;
            ss_meta_r   <= bus.SPI_SLAVE_SS_InLow; ss_sync_r   <= ss_meta_r;   ss_prev_r  <= ss_sync_r;
        end
    end

    // Transmit holding register; loadable in any state.
    always_ff @(posedge SPI_SLAVE_CLOCK_50 or negedge SPI_SLAVE_RESET_InLow) begin
        if (!SPI_SLAVE_RESET_InLow) begin
            hold_r <= {W{1'b0}};
        end else if (bus.SPI_SLAVE_txLoad_InHigh) begin
            hold_r <= bus.SPI_SLAVE_txData_In;
        end else begin
            hold_r <= hold_r;
        end
    end

    // State, shifters, counter and registered outputs.
    always_ff @(posedge SPI_SLAVE_CLOCK_50 or negedge SPI_SLAVE_RESET_InLow) begin
        if (!SPI_SLAVE_RESET_InLow) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            rx_r       <= {W{1'b0}};
            tx_r       <= {W{1'b0}};
            data_r     <= {W{1'b0}};
            miso_r     <= 1'b0;
            valid_r    <= 1'b0;
            ovr_r      <= 1'b0;
            new_data_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            rx_r       <= rx_next_s;
            tx_r       <= tx_next_s;
            data_r     <= data_next_s;
            miso_r     <= miso_next_s;
            valid_r    <= valid_next_s;
            ovr_r      <= ovr_next_s;
            new_data_r <= (state_next_s == DONE);
            busy_r     <= (state_next_s != IDLE);
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        rx_next_s    = rx_r;
        tx_next_s    = tx_r;
        data_next_s  = data_r;
        miso_next_s  = miso_r;
        valid_next_s = valid_r;
        ovr_next_s   = ovr_r;

        if (bus.SPI_SLAVE_rxRead_InHigh) begin
            valid_next_s = 1'b0;
            ovr_next_s   = 1'b0;
        end else begin
            valid_next_s = valid_r;
            ovr_next_s   = ovr_r;
        end

        case (state_r)
            IDLE: begin
                miso_next_s = 1'b0;
                if (ss_fall_s) begin
                    state_next_s = SHIFT;
                    tx_next_s    = hold_r;
                    cnt_next_s   = {CW{1'b0}};
                    miso_next_s  = hold_r[W-1];
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                // A completed word wins over a simultaneous SS release.
                if (cnt_r == CW'(DATAWIDTH_BUS)) begin
                    state_next_s = DONE;
                    data_next_s  = rx_r;
                end else if (ss_sync_r) begin
                    state_next_s = IDLE;
                    miso_next_s  = 1'b0;
                end else if (sck_rise_s) begin
                    rx_next_s  = {rx_r[W-2:0], mosi_sync_r};
                    cnt_next_s = cnt_r + CW'(1);
                end else if (sck_fall_s) begin
                    // The fall that closes the previous word arrives after the
                    // reload in DONE (count 0): present the fresh MSB unshifted.
                    if (cnt_r == {CW{1'b0}}) begin
                        miso_next_s = tx_r[W-1];
                    end else begin
                        tx_next_s   = {tx_r[W-2:0], 1'b0};
                        miso_next_s = tx_r[W-2];
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                cnt_next_s   = {CW{1'b0}};
                tx_next_s    = hold_r;
                valid_next_s = 1'b1;
                if (bus.SPI_SLAVE_rxRead_InHigh) begin
                    ovr_next_s = 1'b0;
                end else begin
                    ovr_next_s = ovr_r | valid_r;
                end
                if (ss_sync_r) begin
                    state_next_s = IDLE;
                    miso_next_s  = 1'b0;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
                miso_next_s  = 1'b0;
            end
        endcase
    end

    assign bus.SPI_SLAVE_MISO_Out    = miso_r;
    assign bus.SPI_SLAVE_data_Out    = data_r;
    assign bus.SPI_SLAVE_newData_Out = new_data_r;
    assign bus.SPI_SLAVE_rxValid_Out = valid_r;
    assign bus.SPI_SLAVE_overrun_Out = ovr_r;
    assign bus.SPI_SLAVE_busy_Out    = busy_r;
endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a mode-0 SPI master model (SCK period 8
// system clocks) drives frames; each scenario task checks its own results
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_slave;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   nd_cnt   = 0;

    always #5 clk = ~clk;

    spi_slave_if #(.DATAWIDTH_BUS(W)) bus ();

    spi_slave #(.DATAWIDTH_BUS(W), .STATE_SIZE(2)) dut (
        .SPI_SLAVE_CLOCK_50    (clk),
        .SPI_SLAVE_RESET_InLow (rst_n),
        .bus                   (bus)
    );

    // Count newData high cycles.
    always @(negedge clk) begin
        if (bus.SPI_SLAVE_newData_Out === 1'b1) nd_cnt++;
    end

    task automatic tx_load(input logic [7:0] v);
        bus.SPI_SLAVE_txData_In = v;
        bus.SPI_SLAVE_txLoad_InHigh = 1'b1;
        @(negedge clk);
        bus.SPI_SLAVE_txLoad_InHigh = 1'b0;
    endtask

    task automatic rd_pulse();
        bus.SPI_SLAVE_rxRead_InHigh = 1'b1;
        @(negedge clk);
        bus.SPI_SLAVE_rxRead_InHigh = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_low();
        bus.SPI_SLAVE_SS_InLow = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        bus.SPI_SLAVE_SS_InLow = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Sends the first nbits of b MSB first; samples MISO just before each rise;
    // lat = negedge index (1..4) after the last raw rise where newData is seen.
    task automatic send_bits(input logic [7:0] b, input int nbits, input logic rd_at_done,
                             output logic [7:0] miso_b, output int lat);
        miso_b = 8'h00;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.SPI_SLAVE_MOSI_In = b[7-i];
            repeat (4) @(negedge clk);
            miso_b[7-i] = bus.SPI_SLAVE_MISO_Out;
            bus.SPI_SLAVE_SCK_In = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == nbits - 1 && lat == 0 && bus.SPI_SLAVE_newData_Out === 1'b1) lat = k;
                if (rd_at_done && i == 7 && k == 4) bus.SPI_SLAVE_rxRead_InHigh = 1'b1;
            end
            bus.SPI_SLAVE_SCK_In = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                bus.SPI_SLAVE_rxRead_InHigh = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.SPI_SLAVE_SCK_In = 1'b0; bus.SPI_SLAVE_MOSI_In = 1'b0; bus.SPI_SLAVE_SS_InLow = 1'b1;
        bus.SPI_SLAVE_txData_In = 8'h00; bus.SPI_SLAVE_txLoad_InHigh = 1'b0; bus.SPI_SLAVE_rxRead_InHigh = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.SPI_SLAVE_data_Out); end
        checks++; if ({bus.SPI_SLAVE_MISO_Out, bus.SPI_SLAVE_newData_Out, bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out} !== 5'b00000) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.SPI_SLAVE_MISO_Out, bus.SPI_SLAVE_newData_Out, bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.SPI_SLAVE_busy_Out !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", bus.SPI_SLAVE_busy_Out); end
    endtask

    task automatic test_basic();
        logic [7:0] m; int lat; int n0;
        tx_load(8'h3C);
        n0 = nd_cnt;
        ss_low();
        checks++; if (bus.SPI_SLAVE_busy_Out !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.SPI_SLAVE_busy_Out); end
        send_bits(8'hA5, 8, 1'b0, m, lat);
        ss_high();
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", bus.SPI_SLAVE_data_Out); end
        checks++; if (m !== 8'h3C) begin failures++; $display("FAIL basic_miso got=%h exp=3c", m); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (nd_cnt - n0 !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", nd_cnt - n0); end
        checks++; if ({bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out, bus.SPI_SLAVE_MISO_Out} !== 4'b1000) begin
            failures++; $display("FAIL basic_flags got=%b exp=1000", {bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out, bus.SPI_SLAVE_MISO_Out}); end
        rd_pulse();
        checks++; if (bus.SPI_SLAVE_rxValid_Out !== 1'b0) begin failures++; $display("FAIL basic_read got=%b exp=0", bus.SPI_SLAVE_rxValid_Out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2; int lat;
        ss_low();
        send_bits(8'h01, 8, 1'b0, m1, lat);
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h01) begin failures++; $display("FAIL b2b_word1 got=%h exp=01", bus.SPI_SLAVE_data_Out); end
        send_bits(8'hFF, 8, 1'b0, m2, lat);
        ss_high();
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'hFF) begin failures++; $display("FAIL b2b_word2 got=%h exp=ff", bus.SPI_SLAVE_data_Out); end
        checks++; if ({bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out} !== 2'b11) begin
            failures++; $display("FAIL b2b_overrun got=%b exp=11", {bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out}); end
        checks++; if (m2 !== 8'h3C) begin failures++; $display("FAIL b2b_retransmit got=%h exp=3c", m2); end
        rd_pulse();
        checks++; if ({bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out} !== 2'b00) begin
            failures++; $display("FAIL b2b_clear got=%b exp=00", {bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out}); end
    endtask

    task automatic test_read_collide();
        logic [7:0] m; int lat;
        ss_low();
        send_bits(8'h11, 8, 1'b0, m, lat);
        send_bits(8'h22, 8, 1'b1, m, lat);
        ss_high();
        checks++; if ({bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out} !== 2'b10) begin
            failures++; $display("FAIL collide_flags got=%b exp=10", {bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out}); end
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h22) begin failures++; $display("FAIL collide_data got=%h exp=22", bus.SPI_SLAVE_data_Out); end
        rd_pulse();
    endtask

    task automatic test_abort();
        logic [7:0] m; int lat; int n0;
        n0 = nd_cnt;
        ss_low();
        send_bits(8'hC3, 5, 1'b0, m, lat);
        ss_high();
        checks++; if (bus.SPI_SLAVE_busy_Out !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.SPI_SLAVE_busy_Out); end
        checks++; if (nd_cnt !== n0) begin failures++; $display("FAIL abort_newdata got=%0d exp=%0d", nd_cnt, n0); end
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h22) begin failures++; $display("FAIL abort_data got=%h exp=22", bus.SPI_SLAVE_data_Out); end
        ss_low();
        send_bits(8'h5A, 8, 1'b0, m, lat);
        ss_high();
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h5A) begin failures++; $display("FAIL abort_next got=%h exp=5a", bus.SPI_SLAVE_data_Out); end
        rd_pulse();
    endtask

    task automatic test_tx_reload();
        logic [7:0] m1, m2; int lat1, lat2;
        ss_low();
        fork
            send_bits(8'h12, 8, 1'b0, m1, lat1);
            begin repeat (30) @(negedge clk); tx_load(8'h81); end
        join
        send_bits(8'h34, 8, 1'b0, m2, lat2);
        ss_high();
        checks++; if (m1 !== 8'h3C) begin failures++; $display("FAIL reload_word1 got=%h exp=3c", m1); end
        checks++; if (m2 !== 8'h81) begin failures++; $display("FAIL reload_word2 got=%h exp=81", m2); end
        checks++; if (bus.SPI_SLAVE_MISO_Out !== 1'b0) begin failures++; $display("FAIL idle_miso got=%b exp=0", bus.SPI_SLAVE_MISO_Out); end
        rd_pulse();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] m; int lat;
        ss_low();
        send_bits(8'hE0, 3, 1'b0, m, lat);
        checks++; if (bus.SPI_SLAVE_busy_Out !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", bus.SPI_SLAVE_busy_Out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.SPI_SLAVE_data_Out, bus.SPI_SLAVE_MISO_Out, bus.SPI_SLAVE_newData_Out, bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out} !== 13'h0) begin
            failures++; $display("FAIL async_reset got=%h exp=0000", {bus.SPI_SLAVE_data_Out, bus.SPI_SLAVE_MISO_Out, bus.SPI_SLAVE_newData_Out, bus.SPI_SLAVE_rxValid_Out, bus.SPI_SLAVE_overrun_Out, bus.SPI_SLAVE_busy_Out}); end
        bus.SPI_SLAVE_SS_InLow = 1'b1; bus.SPI_SLAVE_SCK_In = 1'b0; bus.SPI_SLAVE_MOSI_In = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ss_low();
        send_bits(8'h96, 8, 1'b0, m, lat);
        ss_high();
        checks++; if (bus.SPI_SLAVE_data_Out !== 8'h96) begin failures++; $display("FAIL post_reset_data got=%h exp=96", bus.SPI_SLAVE_data_Out); end
        checks++; if (m !== 8'h00) begin failures++; $display("FAIL post_reset_miso got=%h exp=00", m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_read_collide();
        test_abort();
        test_tx_reload();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
